// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rob_pkg
//  Description : Shared constants and entry record for the reorder buffer.
//                ROB_DEPTH entries addressed by TAG_W-bit tags; tags at or
//                above ROB_DEPTH (notably TAG_INVALID) never name an entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = 4;
    localparam int PTR_W     = $clog2(ROB_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int OP_W      = 4;

    localparam logic [TAG_W-1:0] TAG_INVALID = 4'hF;

    typedef struct packed {
        logic            busy;
        logic            ready;
        logic [4:0]      rd;
        logic [OP_W-1:0] op;
        logic [31:0]     val;
    } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob.sv
`default_nettype none
// ============================================================================
//  Module      : rob
//  Description : 8-entry in-order-retire reorder buffer. One allocation and
//                one commit per cycle, results written back over the CDB,
//                synchronous flush squashes everything.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                flush               - squash all entries
//                alloc_req/rd/op     - allocation request from ID
//                avail_tag, full     - tag for next allocation, no space
//                cdb_valid/tag/val   - execution result broadcast
//                commit_valid/tag/rd/val - registered in-order retirement
//                q_tag/q_ready/q_val - operand forwarding queries
//                                      (only when ROB_FWD_EN is defined)
//  Config      : ROB_FWD_EN - adds two combinational forwarding query ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob
    import rob_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_req,
    input  logic [4:0]       alloc_rd,
    input  logic [OP_W-1:0]  alloc_op,
    output logic [TAG_W-1:0] avail_tag,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val
`ifdef ROB_FWD_EN
    ,
    input  logic [TAG_W-1:0] q_tag   [1:2],
    output logic             q_ready [1:2],
    output logic [31:0]      q_val   [1:2]
`endif
);

    localparam logic [TAG_W-1:0] c_depth_tag = TAG_W'(ROB_DEPTH);
    localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(ROB_DEPTH);

    rob_entry_t       r_entries [ROB_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             r_commit_valid;
    logic [TAG_W-1:0] r_commit_tag;
    logic [4:0]       r_commit_rd;
    logic [31:0]      r_commit_val;

    logic             w_full;
    logic             w_alloc;
    logic             w_commit;
    logic             w_cdb_hit;
    rob_entry_t       w_head_entry;
    logic             w_unused_op;

    // Full is taken from the pre-edge count, so a commit on the same edge
    // never makes room for an allocation on that edge.
    assign w_full       = (r_count == c_depth_cnt);
    assign w_head_entry = r_entries[r_head];

    assign w_alloc   = alloc_req && !w_full && !flush;
    assign w_commit  = w_head_entry.busy && w_head_entry.ready && !flush;
    // Tags outside the entry range (TAG_INVALID included) never match.
    assign w_cdb_hit = cdb_valid && (cdb_tag < c_depth_tag)
                       && r_entries[cdb_tag[PTR_W-1:0]].busy;

    // The op field is carried for downstream consumers only.
    assign w_unused_op = ^w_head_entry.op;

    assign avail_tag    = TAG_W'(r_tail);
    assign full         = w_full;
    assign commit_valid = r_commit_valid;
    assign commit_tag   = r_commit_tag;
    assign commit_rd    = r_commit_rd;
    assign commit_val   = r_commit_val;

    // Pointers, occupancy and the registered commit port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_tag   <= TAG_INVALID;
            r_commit_rd    <= '0;
            r_commit_val   <= '0;
        end else if (flush) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_commit) begin
                r_head         <= r_head + PTR_W'(1);
                r_commit_valid <= 1'b1;
                r_commit_tag   <= TAG_W'(r_head);
                r_commit_rd    <= w_head_entry.rd;
                r_commit_val   <= w_head_entry.val;
            end else begin
                r_commit_valid <= 1'b0;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry array. Allocation targets the tail, which is never busy when an
    // allocation is accepted, so it cannot collide with a CDB write or the
    // head being retired.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_entries[r_tail].busy  <= 1'b1;
                r_entries[r_tail].ready <= 1'b0;
                r_entries[r_tail].rd    <= alloc_rd;
                r_entries[r_tail].op    <= alloc_op;
                r_entries[r_tail].val   <= '0;
            end
            if (w_cdb_hit) begin
                r_entries[cdb_tag[PTR_W-1:0]].ready <= 1'b1;
                r_entries[cdb_tag[PTR_W-1:0]].val   <= cdb_val;
            end
            if (w_commit) begin
                r_entries[r_head].busy <= 1'b0;
            end
        end
    end

`ifdef ROB_FWD_EN
    rob_entry_t w_q_entry [1:2];

    // A result on the CDB this cycle is forwarded ahead of the stored copy.
    always_comb begin
        for (int i = 1; i <= 2; i++) begin
            w_q_entry[i] = r_entries[q_tag[i][PTR_W-1:0]];
            q_ready[i]   = 1'b0;
            q_val[i]     = '0;
            if (q_tag[i] < c_depth_tag) begin
                if (cdb_valid && (cdb_tag == q_tag[i])) begin
                    q_ready[i] = 1'b1;
                    q_val[i]   = cdb_val;
                end else if (w_q_entry[i].busy && w_q_entry[i].ready) begin
                    q_ready[i] = 1'b1;
                    q_val[i]   = w_q_entry[i].val;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob
//  Description : Self-checking bench for rob. A queue-based model of the
//                in-flight instructions predicts commits, avail_tag and full.
//  Config      : ROB_FWD_EN - also exercises the forwarding query ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob;
    import rob_pkg::*;

    logic             clk = 1'b0;
    logic             rst, flush, alloc_req;
    logic [4:0]       alloc_rd;
    logic [OP_W-1:0]  alloc_op;
    logic [TAG_W-1:0] avail_tag;
    logic             full;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_val;
    logic             commit_valid;
    logic [TAG_W-1:0] commit_tag;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_val;
`ifdef ROB_FWD_EN
    logic [TAG_W-1:0] q_tag   [1:2];
    logic             q_ready [1:2];
    logic [31:0]      q_val   [1:2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alloc_req    (alloc_req),
        .alloc_rd     (alloc_rd),
        .alloc_op     (alloc_op),
        .avail_tag    (avail_tag),
        .full         (full),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_val      (cdb_val),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .commit_rd    (commit_rd),
        .commit_val   (commit_val)
`ifdef ROB_FWD_EN
        ,
        .q_tag        (q_tag),
        .q_ready      (q_ready),
        .q_val        (q_val)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          tag;
        int          rd;
        bit          rdy;
        logic [31:0] val;
    } m_t;

    m_t          mq[$];           // in-flight instructions, oldest first
    int          m_tail = 0;      // next tag to hand out
    logic        e_cv   = 1'b0;
    logic [3:0]  e_ctag = 4'hF;
    logic [4:0]  e_crd  = '0;
    logic [31:0] e_cval = '0;

    // Apply current inputs to the model (from pre-edge state), then clock.
    task automatic tick();
        bit pre_full;
        bit do_c;
        m_t h;
        pre_full = (mq.size() == 8);
        if (rst) begin
            mq.delete(); m_tail = 0;
            e_cv = 0; e_ctag = 4'hF; e_crd = '0; e_cval = '0;
        end else if (flush) begin
            mq.delete(); m_tail = 0; e_cv = 0;
        end else begin
            do_c = (mq.size() > 0) && mq[0].rdy;
            if (do_c) h = mq[0];
            if (cdb_valid)
                foreach (mq[i])
                    if (mq[i].tag == int'(cdb_tag)) begin
                        mq[i].rdy = 1'b1;
                        mq[i].val = cdb_val;
                    end
            if (do_c) begin
                e_cv = 1'b1; e_ctag = 4'(h.tag); e_crd = 5'(h.rd); e_cval = h.val;
                void'(mq.pop_front());
            end else begin
                e_cv = 1'b0;
            end
            if (alloc_req && !pre_full) begin
                mq.push_back('{tag: m_tail, rd: int'(alloc_rd), rdy: 1'b0, val: 32'h0});
                m_tail = (m_tail + 1) % 8;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; flush = 0; alloc_req = 0; alloc_rd = '0; alloc_op = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_val = '0;
`ifdef ROB_FWD_EN
        q_tag[1] = 4'hF; q_tag[2] = 4'hF;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({avail_tag, full, commit_valid} !== {4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ptrs act avail=%0d full=%0b cv=%0b exp 0/0/0", avail_tag, full, commit_valid);
        end
        checks++;
        if ({commit_tag, commit_rd, commit_val} !== {4'hF, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_commit act tag=%h rd=%0d val=%h exp F/0/0", commit_tag, commit_rd, commit_val);
        end
    endtask

    task automatic test_basic();
        do_reset();
        alloc_req = 1; alloc_rd = 5'd3; alloc_op = 4'h2;
        tick();
        alloc_req = 0;
        checks++;
        if (avail_tag !== 4'd1) begin
            errors++; $display("FAIL basic_avail act=%0d exp=1", avail_tag);
        end
        cdb_valid = 1; cdb_tag = 4'd0; cdb_val = 32'h55;
        tick();
        cdb_valid = 0;
        checks++;
        if (commit_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early act cv=%0b exp=0", commit_valid);
        end
        tick();
        checks++;
        if ({commit_valid, commit_tag, commit_rd, commit_val} !== {1'b1, 4'd0, 5'd3, 32'h55}) begin
            errors++;
            $display("FAIL basic_commit act cv=%0b tag=%0d rd=%0d val=%h exp 1/0/3/55",
                     commit_valid, commit_tag, commit_rd, commit_val);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc_req = 1; alloc_rd = 5'(i + 1);
            tick();
        end
        checks++;
        if ({full, avail_tag} !== {1'b1, 4'd0}) begin
            errors++; $display("FAIL full_after8 act full=%0b avail=%0d exp 1/0", full, avail_tag);
        end
        tick();   // ninth request, must be dropped
        alloc_req = 0;
        checks++;
        if ({full, avail_tag} !== {1'b1, 4'd0}) begin
            errors++; $display("FAIL full_drop act full=%0b avail=%0d exp 1/0", full, avail_tag);
        end
        cdb_valid = 1; cdb_tag = 4'd0; cdb_val = 32'hABCD;
        tick();
        cdb_valid = 0;
        checks++;
        if (full !== 1'b1) begin
            errors++; $display("FAIL full_hold act=%0b exp=1", full);
        end
        tick();
        checks++;
        if ({full, commit_valid, commit_tag, commit_rd, commit_val} !== {1'b0, 1'b1, 4'd0, 5'd1, 32'hABCD}) begin
            errors++;
            $display("FAIL full_free act full=%0b cv=%0b tag=%0d rd=%0d val=%h exp 0/1/0/1/abcd",
                     full, commit_valid, commit_tag, commit_rd, commit_val);
        end
    endtask

    task automatic test_ooo();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_req = 1; alloc_rd = 5'(10 + i);
            tick();
        end
        alloc_req = 0;
        for (int t = 2; t >= 0; t--) begin
            cdb_valid = 1; cdb_tag = 4'(t); cdb_val = 32'(100 + t);
            tick();
            checks++;
            if (commit_valid !== 1'b0) begin
                errors++; $display("FAIL ooo_premature act cv=%0b tag=%0d exp cv=0", commit_valid, commit_tag);
            end
        end
        cdb_valid = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({commit_valid, commit_tag, commit_rd, commit_val} !== {1'b1, 4'(k), 5'(10 + k), 32'(100 + k)}) begin
                errors++;
                $display("FAIL ooo_order act cv=%0b tag=%0d rd=%0d val=%0d exp 1/%0d/%0d/%0d",
                         commit_valid, commit_tag, commit_rd, commit_val, k, 10 + k, 100 + k);
            end
        end
    endtask

    task automatic test_wrap();
        int ncommit;
        int last_alloc;
        ncommit = 0;
        last_alloc = -1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            alloc_req = (i < 12);
            alloc_rd  = 5'(i);
            cdb_valid = (last_alloc >= 0);
            cdb_tag   = 4'(last_alloc);
            cdb_val   = 32'(1000 + i);
            last_alloc = (i < 12) ? int'(avail_tag) : -1;
            tick();
            if (commit_valid === 1'b1) begin
                checks++;
                if (commit_tag !== 4'(ncommit % 8) || commit_rd !== 5'(ncommit)) begin
                    errors++;
                    $display("FAIL wrap_seq act tag=%0d rd=%0d exp %0d/%0d", commit_tag, commit_rd, ncommit % 8, ncommit);
                end
                ncommit++;
            end
            checks++;
            if (full !== (mq.size() == 8)) begin
                errors++; $display("FAIL wrap_full act=%0b exp=%0b", full, mq.size() == 8);
            end
        end
        idle_inputs();
        checks++;
        if (ncommit != 12 || avail_tag !== 4'd4) begin
            errors++; $display("FAIL wrap_total act commits=%0d avail=%0d exp 12/4", ncommit, avail_tag);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc_req = 1; alloc_rd = 5'(i + 20);
            tick();
        end
        cdb_valid = 1; cdb_tag = 4'd0; cdb_val = 32'h11;
        tick();   // tag 0 ready, commit comes next edge unless squashed
        flush = 1; alloc_req = 1; cdb_valid = 1; cdb_tag = 4'd1; cdb_val = 32'h22;
        tick();
        flush = 0; alloc_req = 0;
        checks++;
        if ({avail_tag, full, commit_valid} !== {4'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL flush_state act avail=%0d full=%0b cv=%0b exp 0/0/0", avail_tag, full, commit_valid);
        end
        cdb_valid = 1; cdb_tag = 4'd2; cdb_val = 32'h33;   // stale tag
        tick();
        cdb_valid = 0;
        alloc_req = 1; alloc_rd = 5'd7;
        tick();
        alloc_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (commit_valid !== 1'b0) begin
                errors++; $display("FAIL flush_stale act cv=%0b tag=%0d exp cv=0", commit_valid, commit_tag);
            end
        end
    endtask

`ifdef ROB_FWD_EN
    task automatic test_fwd();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc_req = 1; alloc_rd = 5'(i + 1);
            tick();
        end
        alloc_req = 0;
        cdb_valid = 1; cdb_tag = 4'd4; cdb_val = 32'd9;
        tick();
        cdb_tag = 4'd5; cdb_val = 32'd7;
        q_tag[1] = 4'd4; q_tag[2] = 4'd5;
        #1;
        checks++;
        if ({q_ready[1], q_val[1], q_ready[2], q_val[2]} !== {1'b1, 32'd9, 1'b1, 32'd7}) begin
            errors++;
            $display("FAIL fwd_query act r1=%0b v1=%0d r2=%0b v2=%0d exp 1/9/1/7", q_ready[1], q_val[1], q_ready[2], q_val[2]);
        end
        q_tag[1] = 4'hF; q_tag[2] = 4'd3;
        #1;
        checks++;
        if ({q_ready[1], q_ready[2]} !== 2'b00) begin
            errors++; $display("FAIL fwd_notready act r1=%0b r2=%0b exp 0/0", q_ready[1], q_ready[2]);
        end
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            alloc_req = ($urandom_range(0, 99) < 55);
            alloc_rd  = 5'($urandom);
            alloc_op  = 4'($urandom);
            cdb_valid = ($urandom_range(0, 99) < 60);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                cdb_tag = 4'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                cdb_tag = 4'($urandom);
            cdb_val   = $urandom;
            tick();
            checks++;
            if ({commit_valid, commit_tag, commit_rd, commit_val} !== {e_cv, e_ctag, e_crd, e_cval}) begin
                errors++;
                $display("FAIL rand_commit cyc=%0d act %0b/%0d/%0d/%h exp %0b/%0d/%0d/%h", c,
                         commit_valid, commit_tag, commit_rd, commit_val, e_cv, e_ctag, e_crd, e_cval);
            end
            checks++;
            if ({avail_tag, full} !== {4'(m_tail), (mq.size() == 8)}) begin
                errors++;
                $display("FAIL rand_ptr cyc=%0d act avail=%0d full=%0b exp %0d/%0b", c,
                         avail_tag, full, m_tail, mq.size() == 8);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_ooo();
        test_wrap();
        test_flush();
`ifdef ROB_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
